// File: rtl/beta_backward_sequencer.sv
// beta_backward_sequencer
//   Drives the soft backward (beta) recursion core through one strand: a base
//   stage at t = n, then backward stages t = N-1 .. 0. Each stage launches the
//   core, waits for its done level, copies the ping-pong bank, and hands the
//   stage to the LLR combiner over valid/ready.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start, N        run request and signed strand length (taken in IDLE/ERR)
//   abort           synchronous abort back to IDLE, err kept
//   calc_beta, t    one-cycle core launch pulse and stage time index
//   core_done       core completion level (may be stale from the prior stage)
//   beta_load       one-cycle bank copy enable (beta_out -> beta_in)
//   stage_valid/stage_t/stage_last/stage_ready  downstream stage handshake
//   busy, done      run in progress, one-cycle end-of-run pulse
//   err             0 none, 1 illegal N, 2 core timeout (sticky)
module beta_backward_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int n          = 10,
    parameter int TIMEOUT    = 4096
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic signed [31:0] N,
    input  logic               abort,
    output logic               calc_beta,
    output logic signed [31:0] t,
    input  logic               core_done,
    output logic               beta_load,
    output logic               stage_valid,
    output logic signed [31:0] stage_t,
    output logic               stage_last,
    input  logic               stage_ready,
    output logic               busy,
    output logic               done,
    output logic [1:0]         err
);

    localparam int                 CW        = $clog2(TIMEOUT) + 1;
    localparam logic signed [31:0] T_BASE    = 32'(n);
    localparam logic signed [31:0] N_MAX     = 32'(DATA_WIDTH);
    localparam logic [CW-1:0]      WAIT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_WAIT, S_LOAD, S_EMIT, S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic signed [31:0] t_q, t_d;
    logic signed [31:0] len_q, len_d;
    logic               base_q, base_d;
    logic [CW-1:0]      wait_q, wait_d;
    logic               done_q, done_d;
    logic [1:0]         err_q, err_d;
    logic               n_legal;

    assign n_legal = (N >= 32'sd1) && (N <= N_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            len_q   <= '0;
            base_q  <= 1'b0;
            wait_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            len_q   <= len_d;
            base_q  <= base_d;
            wait_q  <= wait_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        len_d   = len_q;
        base_d  = base_q;
        wait_d  = wait_q;
        done_d  = 1'b0;
        err_d   = err_q;

        case (state_q)
            S_IDLE, S_ERR: begin
                if (start) begin
                    len_d = N;
                    err_d = 2'd0;
                    if (n_legal) begin
                        t_d     = T_BASE;
                        base_d  = 1'b1;
                        state_d = S_LAUNCH;
                    end else begin
                        t_d     = '0;
                        err_d   = 2'd1;
                        state_d = S_ERR;
                    end
                end
            end
            S_LAUNCH: begin
                // done is not looked at here: a level left high by the
                // previous stage must not complete this one.
                wait_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (core_done) begin
                    state_d = S_LOAD;
                end else if (wait_q == WAIT_LAST) begin
                    t_d     = '0;
                    err_d   = 2'd2;
                    state_d = S_ERR;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_LOAD: state_d = S_EMIT;
            S_EMIT: begin
                if (stage_ready) begin
                    if (base_q) begin
                        // base stage done; recursion starts at N-1
                        base_d  = 1'b0;
                        t_d     = len_q - 32'sd1;
                        state_d = S_LAUNCH;
                    end else if (t_q > 32'sd0) begin
                        t_d     = t_q - 32'sd1;
                        state_d = S_LAUNCH;
                    end else begin
                        t_d     = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // abort beats every transition, including a start seen in ERR
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            t_d     = '0;
            base_d  = 1'b0;
            wait_d  = '0;
            done_d  = 1'b0;
            err_d   = err_q;
        end
    end

    assign calc_beta   = (state_q == S_LAUNCH);
    assign beta_load   = (state_q == S_LOAD);
    assign stage_valid = (state_q == S_EMIT);
    assign stage_t     = stage_valid ? t_q : '0;
    assign stage_last  = stage_valid && (t_q == 32'sd0) && !base_q;
    assign busy        = (state_q != S_IDLE) && (state_q != S_ERR);
    assign t           = t_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_beta_backward_sequencer.sv
module tb_beta_backward_sequencer;
    localparam int DW = 16;
    localparam int NB = 2;
    localparam int TO = 8;

    logic               clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic               core_done = 1'b0, stage_ready = 1'b0;
    logic signed [31:0] N_in = '0;
    logic               calc_beta, beta_load, stage_valid, stage_last, busy, done;
    logic signed [31:0] t, stage_t;
    logic [1:0]         err;

    beta_backward_sequencer #(.DATA_WIDTH(DW), .n(NB), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .N(N_in), .abort(abort),
        .calc_beta(calc_beta), .t(t), .core_done(core_done), .beta_load(beta_load),
        .stage_valid(stage_valid), .stage_t(stage_t), .stage_last(stage_last),
        .stage_ready(stage_ready), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------- behavioural model: run = queue of stage t values ----------------
    int   cyc = 0;
    bit   m_run = 0, m_in_err = 0;
    int   m_q[$];
    int   m_launch = -1, m_load = -1, m_done_at = -1, m_err = 0;
    // observation logs (written only by the compare process)
    int   xfer_log[$];
    int   calc_cnt = 0, load_cnt = 0, done_cnt = 0;
    int   acc_cyc = 0, done_cyc = 0, last_calc_cyc = 0, err_cyc = 0;
    logic [1:0] prev_err = 2'd0;

    always @(negedge clk) begin
        bit ec, el, ev, elast;
        int et;
        cyc++;
        if (!rst_n) begin
            chk("rst_calc_beta", calc_beta, 0);   chk("rst_t", t, 0);
            chk("rst_beta_load", beta_load, 0);   chk("rst_stage_valid", stage_valid, 0);
            chk("rst_stage_t", stage_t, 0);       chk("rst_stage_last", stage_last, 0);
            chk("rst_busy", busy, 0);             chk("rst_done", done, 0);
            chk("rst_err", err, 0);
            m_run = 0; m_in_err = 0; m_q.delete(); m_err = 0; m_done_at = -1;
            prev_err = 2'd0;
        end else begin
            ec    = m_run && (cyc == m_launch);
            el    = m_run && (m_load >= 0) && (cyc == m_load);
            ev    = m_run && (m_load >= 0) && (cyc > m_load);
            et    = m_run ? m_q[0] : 0;
            elast = ev && (m_q.size() == 1);
            chk("calc_beta", calc_beta, ec);
            chk("beta_load", beta_load, el);
            chk("stage_valid", stage_valid, ev);
            chk("t", t, et);
            if (ev) chk("stage_t", stage_t, et);
            chk("stage_last", stage_last, elast);
            chk("busy", busy, m_run);
            chk("done", done, cyc == m_done_at);
            chk("err", err, m_err);

            if (calc_beta) begin calc_cnt++; last_calc_cyc = cyc; end
            if (beta_load) load_cnt++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (stage_valid && stage_ready) xfer_log.push_back(stage_t);
            if (err != prev_err) err_cyc = cyc;
            prev_err = err;

            if (m_run) begin
                if (abort) begin
                    m_run = 0; m_q.delete();
                end else if (m_load < 0) begin
                    if (cyc > m_launch) begin
                        if (core_done) m_load = cyc + 1;
                        else if (cyc - m_launch == TO) begin
                            m_run = 0; m_q.delete(); m_err = 2; m_in_err = 1;
                        end
                    end
                end else if (cyc > m_load && stage_ready) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) begin m_run = 0; m_done_at = cyc + 1; end
                    else begin m_launch = cyc + 1; m_load = -1; end
                end
            end else if (m_in_err && abort) begin
                m_in_err = 0;
            end else if (start) begin
                acc_cyc = cyc; m_err = 0;
                if (N_in < 1 || N_in > DW) begin
                    m_err = 1; m_in_err = 1;
                end else begin
                    m_in_err = 0; m_run = 1; m_q.delete();
                    m_q.push_back(NB);
                    for (int k = N_in - 1; k >= 0; k--) m_q.push_back(k);
                    m_launch = cyc + 1; m_load = -1;
                end
            end
        end
    end

    // ---------------- core emulation ----------------
    int core_mode = 0;     // 0 latency-driven, 1 done stuck high
    int core_lat_fix = 0;  // 0 = random latency 1..4
    int hang_at = 0, launches = 0, rem = 0;
    always @(posedge clk) begin
        #2;
        if (core_mode == 1) core_done = 1'b1;
        else if (calc_beta) begin
            launches++;
            rem = (core_lat_fix > 0) ? core_lat_fix : int'($urandom_range(1, 4));
            if (launches == hang_at) begin rem = 0; core_done = 1'b0; end
        end else if (rem > 0) begin
            rem--;
            core_done = (rem == 0);
        end
    end

    // ---------------- downstream ready ----------------
    int rdy_mode = 0;      // 0 random, 1 high, 2 low, 3 stall stall_t for 7 cycles
    int stall_t = 1, stall_seen = 0;
    always @(posedge clk) begin
        #1;
        if (rdy_mode != 3) stall_seen = 0;
        case (rdy_mode)
            1: stage_ready = 1'b1;
            2: stage_ready = 1'b0;
            3: if (stage_valid && stage_t == stall_t && stall_seen < 7) begin
                   stage_ready = 1'b0; stall_seen++;
               end else stage_ready = 1'b1;
            default: stage_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start(input int nv);
        start = 1'b1; N_in = nv; step(); start = 1'b0;
    endtask

    task automatic wait_run(input string nm, input int budget);
        int k = 0;
        while (m_run && k < budget) begin step(); k++; end
        if (m_run) chk({nm, "_run_bound"}, 1, 0);
        step(); step();
    endtask

    task automatic chk_seq(input string nm, input int x0, input int e[$]);
        chk({nm, "_len"}, xfer_log.size() - x0, e.size());
        foreach (e[i])
            chk(nm, (x0 + i < xfer_log.size()) ? xfer_log[x0 + i] : -1, e[i]);
    endtask

    initial begin
        int x0, c0, l0, d0, nv, k;
        int e[$];
        bit found;
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b1;
        step();

        // 1: nominal N=4, done 1 cycle after launch, ready high
        rdy_mode = 1; core_lat_fix = 1; step();
        x0 = xfer_log.size(); c0 = calc_cnt; l0 = load_cnt; d0 = done_cnt;
        pulse_start(4); wait_run("t1", 200);
        e = {2, 3, 2, 1, 0}; chk_seq("t1_seq", x0, e);
        chk("t1_calc_pulses", calc_cnt - c0, 5);
        chk("t1_load_pulses", load_cnt - l0, 5);
        chk("t1_done_pulses", done_cnt - d0, 1);
        chk("t1_done_latency", done_cyc - acc_cyc, 21);
        chk("t1_busy_after", busy, 0);

        // 2: stale done held high, N=1
        core_mode = 1; step();
        x0 = xfer_log.size(); c0 = calc_cnt; d0 = done_cnt;
        pulse_start(1); wait_run("t2", 100);
        e = {2, 0}; chk_seq("t2_seq", x0, e);
        chk("t2_calc_pulses", calc_cnt - c0, 2);
        chk("t2_done_latency", done_cyc - acc_cyc, 9);
        chk("t2_done_pulses", done_cnt - d0, 1);
        core_mode = 0;

        // 3: 7-cycle backpressure on stage t=1, N=3
        rdy_mode = 3; stall_t = 1; step(); step();
        x0 = xfer_log.size(); c0 = calc_cnt;
        pulse_start(3); wait_run("t3", 200);
        e = {2, 2, 1, 0}; chk_seq("t3_seq", x0, e);
        chk("t3_calc_pulses", calc_cnt - c0, 4);
        chk("t3_done_latency", done_cyc - acc_cyc, 24);
        rdy_mode = 1;

        // 4: core hangs on the second stage
        c0 = calc_cnt; d0 = done_cnt; hang_at = launches + 2;
        pulse_start(5); wait_run("t4", 200);
        chk("t4_err", err, 2);
        chk("t4_busy", busy, 0);
        chk("t4_calc_pulses", calc_cnt - c0, 2);
        chk("t4_err_delay", err_cyc - last_calc_cyc, TO + 1);
        chk("t4_no_done", done_cnt - d0, 0);
        hang_at = 0;
        x0 = xfer_log.size();
        pulse_start(2); wait_run("t4b", 200);
        chk("t4b_err_cleared", err, 0);
        e = {2, 1, 0}; chk_seq("t4b_seq", x0, e);

        // 5: illegal lengths, then the maximum
        c0 = calc_cnt;
        pulse_start(0); step();
        chk("t5_err_n0", err, 1);
        pulse_start(DW + 1); step();
        chk("t5_err_nmax1", err, 1);
        chk("t5_no_calc", calc_cnt - c0, 0);
        chk("t5_busy", busy, 0);
        x0 = xfer_log.size(); c0 = calc_cnt; l0 = load_cnt;
        pulse_start(DW); wait_run("t5", 1000);
        chk("t5_stages", xfer_log.size() - x0, DW + 1);
        chk("t5_calc_pulses", calc_cnt - c0, DW + 1);
        chk("t5_load_pulses", load_cnt - l0, DW + 1);
        chk("t5_err_cleared", err, 0);

        // 6a: abort in WAIT of stage t=3
        core_lat_fix = 3; d0 = done_cnt; found = 0;
        pulse_start(4);
        for (k = 0; k < 100 && !found; k++) begin
            if (calc_beta && t == 3) found = 1;
            else step();
        end
        chk("t6_found_t3", found, 1);
        step(); abort = 1'b1; step(); abort = 1'b0;
        chk("t6_abort_busy", busy, 0);
        chk("t6_abort_err", err, 0);
        step(); step();
        chk("t6_abort_no_done", done_cnt - d0, 0);

        // 6b: reset asserted mid-EMIT
        rdy_mode = 2; core_lat_fix = 1; found = 0;
        pulse_start(2);
        for (k = 0; k < 50 && !found; k++) begin
            if (stage_valid) found = 1;
            else step();
        end
        chk("t6_found_emit", found, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", stage_valid, 0); chk("t6_rst_t", t, 0);
        chk("t6_rst_busy", busy, 0);         chk("t6_rst_stage_t", stage_t, 0);
        @(posedge clk); @(posedge clk); #1; rst_n = 1'b1; rdy_mode = 1;
        step();
        x0 = xfer_log.size();
        pulse_start(3); wait_run("t6c", 200);
        e = {2, 2, 1, 0}; chk_seq("t6c_seq", x0, e);

        // randomized runs: lengths, latencies, backpressure, stray start/abort
        core_lat_fix = 0; rdy_mode = 0;
        for (int it = 0; it < 40; it++) begin
            core_mode = ($urandom_range(0, 7) == 0) ? 1 : 0;
            if ($urandom_range(0, 7) == 0) hang_at = launches + int'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) nv = int'($urandom_range(0, DW + 3)) - 1;
            else nv = int'($urandom_range(1, DW));
            pulse_start(nv);
            k = 0;
            while (m_run && k < 3000) begin
                start = ($urandom_range(0, 40) == 0);
                abort = ($urandom_range(0, 90) == 0);
                step(); k++;
            end
            start = 1'b0; abort = 1'b0;
            if (m_run) chk("rand_run_bound", 1, 0);
            if (m_in_err && $urandom_range(0, 1) == 1) begin
                abort = 1'b1; step(); abort = 1'b0;
            end
            step(); step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, %0d/%0d", n_pass, n_chk);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/beta_backward_sequencer.md
Name: beta_backward_sequencer

Overview:
Control FSM that runs the soft backward (beta) recursion core across all time steps of one received strand. It issues the terminal/base stage, then the backward stages t = N-1 down to 0, one per core run. For each stage it pulses the core start, waits for completion, commands the beta ping-pong bank to copy core output into core input, and hands each finished stage to the downstream LLR combiner over a valid/ready handshake. It also checks that the runtime length is legal and guards each core run with a watchdog.

Parameters:
DATA_WIDTH, 32, maximum post-IDS strand length; upper bound for N
n, 10, pre-IDS codeword length; t value of the base stage
TIMEOUT, 4096, max cycles in WAIT for core done before error; must be >= 2

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  start request; sampled only in IDLE
N  in  32  post-IDS length, signed int; captured on start acceptance
abort  in  1  synchronous abort; returns to IDLE from any non-IDLE state
calc_beta  out  1  one-cycle pulse to core: begin stage
t  out  32  signed time index driven to core; stable from LAUNCH through EMIT
core_done  in  1  core done; level signal, may still be high from the previous stage
beta_load  out  1  one-cycle enable: bank copies beta_out into beta_in
stage_valid  out  1  stage result available downstream
stage_t  out  32  t of the presented stage; valid while stage_valid
stage_last  out  1  presented stage is the final one (t=0)
stage_ready  in  1  downstream accepts the stage
busy  out  1  high in every state except IDLE and ERR
done  out  1  one-cycle pulse after the final stage is accepted
err  out  2  0 none, 1 illegal N, 2 core timeout; sticky until next accepted start or reset

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0: calc_beta, t, beta_load, stage_valid, stage_t, stage_last, busy, done, err. Internal counters are cleared.
- States: IDLE, LAUNCH, WAIT, LOAD, EMIT, ERR.
- IDLE, start=1: capture N into N_q and clear err.
  - If N_q < 1 or N_q > DATA_WIDTH: go to ERR, err=1.
  - Otherwise t<=n, base flag=1, go to LAUNCH.
  - Accepted start to calc_beta high is 1 cycle.
- LAUNCH: calc_beta=1 for exactly this cycle. Clear wait_cnt. Next state WAIT.
- WAIT: core_done is never sampled in the LAUNCH cycle, only from the cycle after LAUNCH on. This prevents a stale level-high done from the prior stage being counted.
  - core_done=1: go to LOAD.
  - Otherwise wait_cnt++. When wait_cnt reaches TIMEOUT-1 with no done: go to ERR, err=2.
- LOAD: beta_load=1 for one cycle. Next state EMIT.
- EMIT: stage_valid=1, stage_t=t, stage_last=(t==0 and base flag=0).
  - Outputs hold until stage_valid && stage_ready in the same cycle (transfer). stage_ready is allowed to be high before valid; the transfer then happens on the first EMIT cycle.
  - Transfer on the base stage: clear base flag, t<=N_q-1, go to LAUNCH.
  - Transfer with t>0 (non-base): t<=t-1, go to LAUNCH.
  - Transfer on the last stage: done pulse next cycle, go to IDLE, t<=0.
- Stage order: n, N_q-1, N_q-2, …, 0. Total N_q+1 stages, N_q+1 calc_beta pulses, N_q+1 beta_load pulses.
- Edge case N_q=1: stages n, 0.
- Edge case n = N_q-1: that t value is issued twice (base, then first recursion step). This is intended.
- ERR: busy=0, no core pulses. start=1 is accepted exactly as in IDLE. abort=1 in ERR goes to IDLE with err held.
- abort (non-IDLE states): next cycle state=IDLE, outputs deasserted, err unchanged, no done pulse. Abort in LAUNCH does not suppress that cycle's calc_beta pulse. The core result is discarded.
- Priority: rst_n > abort > state transitions. start while busy is ignored.
- Arithmetic: t is signed 32-bit and is never decremented below 0. wait_cnt is width clog2(TIMEOUT)+1.
- Per-stage minimum latency (ready held high, core done 1 cycle after launch): LAUNCH, WAIT, LOAD, EMIT = 4 cycles.
- Reset mid-operation: immediate return to IDLE with all outputs 0, regardless of state.

Test Plan:
1. Nominal run, n=2, N=4, core done 1 cycle after each calc_beta, ready tied 1 -> stage_t sequence 2,3,2,1,0; 5 calc_beta and 5 beta_load pulses; stage_last only on stage_t=0; done pulse 20 cycles after start+1; busy low afterwards.
2. Stale done: core_done held 1 throughout, N=1 -> no stage skipped; each stage still shows LAUNCH→WAIT→LOAD→EMIT; stage_t 2,0; done asserted.
3. Backpressure: N=3, stage_ready low for 7 cycles on stage_t=1 -> stage_valid, stage_t=1, t held 7 cycles; no calc_beta during stall; sequence continues 1,0 after ready.
4. Timeout: TIMEOUT=8, core never asserts done on the second stage -> ERR after exactly 8 WAIT cycles, err=2, busy=0. A new start with N=2 clears err and runs 3 stages.
5. Illegal N: start with N=0, then N=DATA_WIDTH+1 -> err=1 each time, zero calc_beta pulses. N=DATA_WIDTH runs DATA_WIDTH+1 stages.
6. Abort and reset: abort in WAIT of stage_t=3 -> IDLE next cycle, no done, err=0. rst_n low mid-EMIT -> all outputs 0 asynchronously. start after release runs normally.
